// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - pong match sequencer: attract, serve delay, pause, speed ramp, game over
module pong_match_ctrl #(
    parameter logic [21:0] PRESC_INIT   = 22'd250000,
    parameter logic [21:0] PRESC_MIN    = 22'd100000,
    parameter logic [21:0] PRESC_STEP   = 22'd10000,
    parameter logic [7:0]  RAMP_FRAMES  = 8'd120,
    parameter logic [7:0]  SERVE_FRAMES = 8'd60
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        frame_tick,
    input  logic        btn_start,
    input  logic        btn_pause,
    input  logic [1:0]  p1_score,
    input  logic [1:0]  p2_score,
    input  logic        gamestop,
    output logic        start,
    output logic [21:0] prescaler,
    output logic [2:0]  state,
    output logic [7:0]  serve_cnt,
    output logic [1:0]  winner
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam logic [22:0] MIN_PLUS_STEP = {1'b0, PRESC_MIN} + {1'b0, PRESC_STEP};

    state_t      cur_state;
    logic [7:0]  ramp_cnt;
    logic        btn_start_q;
    logic        btn_pause_q;
    logic        gamestop_q;
    logic [1:0]  p1_q;
    logic [1:0]  p2_q;

    logic        start_edge;
    logic        pause_edge;
    logic        gs_rise;
    logic        score_chg;
    logic        ramp_hit;
    logic [21:0] presc_ramped;

    assign state      = cur_state;
    assign start_edge = btn_start & ~btn_start_q;
    assign pause_edge = btn_pause & ~btn_pause_q;
    assign gs_rise    = gamestop & ~gamestop_q;
    assign score_chg  = (p1_score != p1_q) || (p2_score != p2_q);
    assign ramp_hit   = ({1'b0, ramp_cnt} + 9'd1) >= {1'b0, RAMP_FRAMES};

    // Compare before subtracting so the ramp clamps at the floor without wrapping.
    assign presc_ramped = ({1'b0, prescaler} < MIN_PLUS_STEP) ? PRESC_MIN
                                                              : (prescaler - PRESC_STEP);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cur_state   <= ST_IDLE;
            start       <= 1'b0;
            prescaler   <= PRESC_INIT;
            serve_cnt   <= 8'd0;
            winner      <= 2'b00;
            ramp_cnt    <= 8'd0;
            btn_start_q <= 1'b0;
            btn_pause_q <= 1'b0;
            gamestop_q  <= 1'b0;
            p1_q        <= 2'd0;
            p2_q        <= 2'd0;
        end else begin
            btn_start_q <= btn_start;
            btn_pause_q <= btn_pause;
            gamestop_q  <= gamestop;
            p1_q        <= p1_score;
            p2_q        <= p2_score;

            case (cur_state)
                ST_IDLE, ST_OVER: begin
                    if (start_edge) begin
                        cur_state <= ST_SERVE;
                        start     <= 1'b0;
                        serve_cnt <= SERVE_FRAMES;
                        prescaler <= PRESC_INIT;
                        ramp_cnt  <= 8'd0;
                        winner    <= 2'b00;
                    end
                end

                ST_SERVE: begin
                    if (frame_tick) begin
                        // A zero-length serve also leaves on the first tick.
                        if (serve_cnt <= 8'd1) begin
                            cur_state <= ST_PLAY;
                            start     <= 1'b1;
                            serve_cnt <= 8'd0;
                        end else begin
                            serve_cnt <= serve_cnt - 8'd1;
                        end
                    end
                end

                ST_PLAY: begin
                    if (gs_rise) begin
                        // Engine clears scores as it stops, so use the pre-clear copy.
                        cur_state <= ST_OVER;
                        start     <= 1'b0;
                        winner    <= (p1_q == 2'd2) ? 2'b01 : 2'b10;
                    end else if (score_chg) begin
                        cur_state <= ST_SERVE;
                        start     <= 1'b0;
                        serve_cnt <= SERVE_FRAMES;
                        prescaler <= PRESC_INIT;
                        ramp_cnt  <= 8'd0;
                    end else if (pause_edge) begin
                        cur_state <= ST_PAUSE;
                        start     <= 1'b0;
                    end else if (frame_tick) begin
                        if (ramp_hit) begin
                            ramp_cnt  <= 8'd0;
                            prescaler <= presc_ramped;
                        end else begin
                            ramp_cnt <= ramp_cnt + 8'd1;
                        end
                    end
                end

                ST_PAUSE: begin
                    if (pause_edge) begin
                        cur_state <= ST_PLAY;
                        start     <= 1'b1;
                    end
                end

                default: begin
                    cur_state <= ST_IDLE;
                    start     <= 1'b0;
                    serve_cnt <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb/tb_pong_match_ctrl.sv - directed-vector bench for pong_match_ctrl
module tb_pong_match_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        frame_tick;
    logic        btn_start;
    logic        btn_pause;
    logic [1:0]  p1_score;
    logic [1:0]  p2_score;
    logic        gamestop;

    logic        start;
    logic [21:0] prescaler;
    logic [2:0]  state;
    logic [7:0]  serve_cnt;
    logic [1:0]  winner;

    logic        start_b;
    logic [21:0] prescaler_b;
    logic [2:0]  state_b;
    logic [7:0]  serve_cnt_b;
    logic [1:0]  winner_b;

    int n_checks = 0;
    int n_fail   = 0;

    pong_match_ctrl dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .frame_tick (frame_tick),
        .btn_start  (btn_start),
        .btn_pause  (btn_pause),
        .p1_score   (p1_score),
        .p2_score   (p2_score),
        .gamestop   (gamestop),
        .start      (start),
        .prescaler  (prescaler),
        .state      (state),
        .serve_cnt  (serve_cnt),
        .winner     (winner)
    );

    pong_match_ctrl #(.PRESC_STEP(22'd150000)) dut_big_step (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .frame_tick (frame_tick),
        .btn_start  (btn_start),
        .btn_pause  (btn_pause),
        .p1_score   (p1_score),
        .p2_score   (p2_score),
        .gamestop   (gamestop),
        .start      (start_b),
        .prescaler  (prescaler_b),
        .state      (state_b),
        .serve_cnt  (serve_cnt_b),
        .winner     (winner_b)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK) frame_tick = 1'b1;
        @(negedge CLK) frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_start();
        @(negedge CLK) btn_start = 1'b1;
        @(negedge CLK) btn_start = 1'b0;
    endtask

    task automatic press_pause();
        @(negedge CLK) btn_pause = 1'b1;
        @(negedge CLK) btn_pause = 1'b0;
    endtask

    initial begin
        RST_N      = 1'b0;
        frame_tick = 1'b0;
        btn_start  = 1'b0;
        btn_pause  = 1'b0;
        p1_score   = 2'd0;
        p2_score   = 2'd0;
        gamestop   = 1'b0;
        repeat (2) @(negedge CLK);

        check_val("rst_state", 32'(state), 32'd0);
        check_val("rst_start", 32'(start), 32'd0);
        check_val("rst_presc", 32'(prescaler), 32'd250000);
        check_val("rst_serve", 32'(serve_cnt), 32'd0);
        check_val("rst_winner", 32'(winner), 32'd0);
        check_val("rst_b_state", 32'(state_b), 32'd0);
        check_val("rst_b_start", 32'(start_b), 32'd0);
        check_val("rst_b_serve", 32'(serve_cnt_b), 32'd0);
        check_val("rst_b_winner", 32'(winner_b), 32'd0);

        @(negedge CLK) RST_N = 1'b1;

        press_start();
        check_val("go_state", 32'(state), 32'd1);
        check_val("go_serve", 32'(serve_cnt), 32'd60);
        check_val("go_start", 32'(start), 32'd0);

        press_pause();
        check_val("serve_pause_ign", 32'(state), 32'd1);

        for (int i = 0; i < 60; i++) begin
            check_val("serve_state", 32'(state), 32'd1);
            check_val("serve_cnt", 32'(serve_cnt), 32'(60 - i));
            tick();
        end
        check_val("play_state", 32'(state), 32'd2);
        check_val("play_start", 32'(start), 32'd1);
        check_val("play_serve0", 32'(serve_cnt), 32'd0);
        check_val("b_play_state", 32'(state_b), 32'd2);
        check_val("b_play_start", 32'(start_b), 32'd1);

        ticks(119);
        check_val("ramp_pre", 32'(prescaler), 32'd250000);
        tick();
        check_val("ramp_1", 32'(prescaler), 32'd240000);
        check_val("b_ramp_1", 32'(prescaler_b), 32'd100000);
        ticks(120);
        check_val("ramp_2", 32'(prescaler), 32'd230000);
        check_val("b_ramp_2", 32'(prescaler_b), 32'd100000);

        ticks(60);
        @(negedge CLK) btn_pause = 1'b1;
        @(negedge CLK);
        check_val("pause_state", 32'(state), 32'd3);
        check_val("pause_start", 32'(start), 32'd0);
        repeat (9) @(negedge CLK);
        check_val("pause_held", 32'(state), 32'd3);
        btn_pause = 1'b0;
        ticks(130);
        check_val("pause_presc", 32'(prescaler), 32'd230000);
        check_val("pause_state2", 32'(state), 32'd3);
        press_pause();
        check_val("resume_state", 32'(state), 32'd2);
        check_val("resume_start", 32'(start), 32'd1);
        ticks(59);
        check_val("resume_presc", 32'(prescaler), 32'd230000);
        tick();
        check_val("ramp_3", 32'(prescaler), 32'd220000);

        ticks(120 * 11);
        check_val("ramp_14", 32'(prescaler), 32'd110000);
        ticks(120);
        check_val("ramp_15", 32'(prescaler), 32'd100000);
        ticks(120);
        check_val("ramp_floor", 32'(prescaler), 32'd100000);
        check_val("b_ramp_floor", 32'(prescaler_b), 32'd100000);

        @(negedge CLK) p2_score = 2'd1;
        @(negedge CLK);
        check_val("pt_start", 32'(start), 32'd0);
        check_val("pt_state", 32'(state), 32'd1);
        check_val("pt_presc", 32'(prescaler), 32'd250000);
        check_val("pt_serve", 32'(serve_cnt), 32'd60);
        check_val("b_pt_presc", 32'(prescaler_b), 32'd250000);

        @(negedge CLK) p1_score = 2'd2;
        @(negedge CLK);
        check_val("serve_score_ign", 32'(state), 32'd1);
        ticks(60);
        check_val("play2_state", 32'(state), 32'd2);
        ticks(5);

        @(negedge CLK) begin
            gamestop = 1'b1;
            p1_score = 2'd0;
            p2_score = 2'd0;
        end
        @(negedge CLK);
        check_val("over_state", 32'(state), 32'd4);
        check_val("over_winner", 32'(winner), 32'd1);
        check_val("over_start", 32'(start), 32'd0);
        repeat (5) @(negedge CLK);
        ticks(3);
        check_val("over_held_state", 32'(state), 32'd4);
        check_val("over_held_winner", 32'(winner), 32'd1);

        press_start();
        check_val("restart_state", 32'(state), 32'd1);
        check_val("restart_winner", 32'(winner), 32'd0);
        check_val("restart_presc", 32'(prescaler), 32'd250000);
        check_val("restart_serve", 32'(serve_cnt), 32'd60);
        @(negedge CLK) gamestop = 1'b0;
        ticks(60);
        check_val("play3_state", 32'(state), 32'd2);

        @(negedge CLK) begin
            gamestop = 1'b1;
            p2_score = 2'd1;
        end
        @(negedge CLK);
        check_val("simul_state", 32'(state), 32'd4);
        check_val("simul_winner", 32'(winner), 32'd2);

        press_start();
        @(negedge CLK) gamestop = 1'b0;
        ticks(60);
        ticks(130);
        check_val("play4_presc", 32'(prescaler), 32'd240000);
        press_pause();
        check_val("pause2_state", 32'(state), 32'd3);

        @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check_val("arst_state", 32'(state), 32'd0);
        check_val("arst_start", 32'(start), 32'd0);
        check_val("arst_presc", 32'(prescaler), 32'd250000);
        check_val("arst_serve", 32'(serve_cnt), 32'd0);
        check_val("arst_winner", 32'(winner), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
